execute_cc_unit: RTL
====================

Name: execute_cc_unit

Overview:
- Execute-stage back end of the Y86-64 pipeline. Sits directly downstream of the 64-bit ALU (add/sub/and/xor datapath with signed-overflow output).
- Derives ZF/SF/OF from the ALU result and holds them in the condition-code register.
- Evaluates the branch/cmov condition and owns the E-to-M pipeline register.
- Its outputs feed the memory stage and the forwarding/hazard logic.

Parameters:
- WIDTH, 64, datapath width of valE/valA.
- REG_W, 4, register-ID width; RNONE is all ones.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- e_icode  in  4  instruction code in execute.
- e_ifun  in  4  function code in execute (ALU op or condition).
- e_stat  in  2  status in execute.
- e_valE  in  WIDTH  ALU result.
- e_of  in  1  signed-overflow flag from the ALU.
- e_valA  in  WIDTH  pass-through operand.
- e_dstE  in  REG_W  destination for valE.
- e_dstM  in  REG_W  destination for valM.
- cc_block  in  1  suppresses CC update (exception in M or W).
- m_stall  in  1  hold the M register.
- m_bubble  in  1  insert a NOP into the M register.
- e_cnd  out  1  condition result, combinational, for the current E instruction.
- e_dstE_sel  out  REG_W  e_dstE after cmov squash (to forwarding).
- cc_zf  out  1  registered ZF.
- cc_sf  out  1  registered SF.
- cc_of  out  1  registered OF.
- M_stat  out  2  registered M-stage field.
- M_icode  out  4  registered M-stage field.
- M_cnd  out  1  registered M-stage field.
- M_valE  out  WIDTH  registered M-stage field.
- M_valA  out  WIDTH  registered M-stage field.
- M_dstE  out  REG_W  registered M-stage field.
- M_dstM  out  REG_W  registered M-stage field.

Behaviour:
- Reset, synchronous and highest priority:
  - cc_zf=1, cc_sf=0, cc_of=0.
  - M_icode=NOP(1), M_stat=AOK, M_cnd=0, M_valE=0, M_valA=0, M_dstE=RNONE, M_dstM=RNONE.
- Flag derivation, combinational:
  - zf_n = (e_valE==0); sf_n = e_valE[WIDTH-1].
  - of_n = e_of when ifun is ADD(0) or SUB(1); of_n = 0 when ifun is AND(2) or XOR(3).
- CC update:
  - Load {zf_n,sf_n,of_n} at the clock edge when e_icode==OPQ(6), e_stat==AOK and cc_block==0. Otherwise hold.
  - m_stall does not block the CC update; only rst and cc_block do.
- CC latency: 1 cycle. An OPQ in E at cycle t makes its flags visible at t+1, so a directly following jXX/cmov sees them.
- e_cnd, from the registered CC, with X = cc_sf^cc_of:
  - ifun0 (always): 1.
  - ifun1 (LE): X|ZF.
  - ifun2 (L): X.
  - ifun3 (E): ZF.
  - ifun4 (NE): ~ZF.
  - ifun5 (GE): ~X.
  - ifun6 (G): ~X&~ZF.
  - ifun 7–15: 0.
  - e_cnd is meaningful only for icode JXX(7) and CMOVXX/RRMOVQ(2). For any other icode, e_cnd is forced to 1.
- cmov squash: e_dstE_sel = RNONE when e_icode==2 and e_cnd==0; otherwise e_dstE_sel = e_dstE.
- M register priority is rst > m_bubble > m_stall > load:
  - m_bubble: load the reset/NOP values; CC update still follows the CC rule.
  - m_stall: hold all M_* outputs.
  - Load: M_* <= {e_stat, e_icode, e_cnd, e_valE, e_valA, e_dstE_sel, e_dstM}.
  - m_bubble and m_stall together: bubble wins.
- A non-AOK e_stat still propagates into M unmodified; only CC writes are blocked.
- Width rule: no sign extension or truncation; valE and valA pass through bit-exact.
- Reset mid-operation: all state reinitialises the same cycle; no partial updates.

Decomposition:
- Shared package y86_pkg:
  - icode constants: HALT=0, NOP=1, CMOVXX=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B.
  - ALU ifun constants: ADD=0, SUB=1, AND=2, XOR=3.
  - Condition ifun constants: 0–6.
  - Stat encoding: AOK=0, HLT=1, ADR=2, INS=3.
  - RNONE=4'hF.
- One natural combinational sub-module: cond_eval (inputs ifun, zf, sf, of; output cnd). It is reused by the fetch-stage predictor check.

Test Plan:
- Reset, then idle: cc={1,0,0}; M_icode=1; M_dstE=F; JXX ifun3 -> e_cnd=1.
- OPQ SUB, valE=0, of=0, ifun1, cc_block=0 -> next cycle cc={1,0,0}. Following JXX ifun4 -> e_cnd=0; M_cnd=0 one cycle later.
- OPQ ADD, valE=64'h8000_0000_0000_0000, of=1 -> cc={0,1,1}. Then JXX ifun2 (L) -> e_cnd=0; ifun5 (GE) -> e_cnd=1.
- OPQ XOR, valE=64'h1, e_of=1 -> cc={0,0,0} (OF forced low). Then CMOVXX ifun3, dstE=3 -> e_dstE_sel=F, M_dstE=F.
- OPQ with cc_block=1, valE=0 -> CC unchanged. Same instruction with e_stat=ADR and cc_block=0 -> CC unchanged, M_stat=ADR.
- m_stall=1 for 2 cycles -> M_* frozen. m_stall=1 with m_bubble=1 -> M_icode=1, M_dstE=F. rst pulse mid-stream -> all reset values on the next edge.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction, ALU and condition codes,
// status values and the "no register" ID.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [3:0] A_ADD = 4'h0;
   localparam logic [3:0] A_SUB = 4'h1;
   localparam logic [3:0] A_AND = 4'h2;
   localparam logic [3:0] A_XOR = 4'h3;

   localparam logic [3:0] C_ALW = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [1:0] S_AOK = 2'd0;
   localparam logic [1:0] S_HLT = 2'd1;
   localparam logic [1:0] S_ADR = 2'd2;
   localparam logic [1:0] S_INS = 2'd3;

   localparam logic [3:0] RNONE = 4'hF;

   // Logical ops cannot overflow, so only add/sub pass the ALU flag on.
   function automatic logic alu_of(input logic [3:0] ifun,
                                   input logic       of);
      return ((ifun == A_ADD) || (ifun == A_SUB)) ? of : 1'b0;
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Y86-64 jXX/cmovXX condition evaluation from ZF/SF/OF.
// Purely combinational; shared with the fetch-stage predictor check.
module cond_eval
   import y86_pkg::*;
(
   input  logic [3:0] ifun,
   input  logic       zf,
   input  logic       sf,
   input  logic       of,
   output logic       cnd
);

   logic lt;

   assign lt = sf ^ of;

   always_comb begin
      cnd = 1'b0;
      case (ifun)
         C_ALW:   cnd = 1'b1;
         C_LE:    cnd = lt | zf;
         C_L:     cnd = lt;
         C_E:     cnd = zf;
         C_NE:    cnd = ~zf;
         C_GE:    cnd = ~lt;
         C_G:     cnd = ~lt & ~zf;
         default: cnd = 1'b0;
      endcase
   end

endmodule

// File: rtl/execute_cc_unit.sv
// Execute-stage back end: condition-code register, branch/cmov
// condition, cmov destination squash and the E-to-M pipeline register.
module execute_cc_unit
   import y86_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int REG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       e_icode,
   input  logic [3:0]       e_ifun,
   input  logic [1:0]       e_stat,
   input  logic [WIDTH-1:0] e_valE,
   input  logic             e_of,
   input  logic [WIDTH-1:0] e_valA,
   input  logic [REG_W-1:0] e_dstE,
   input  logic [REG_W-1:0] e_dstM,
   input  logic             cc_block,
   input  logic             m_stall,
   input  logic             m_bubble,
   output logic             e_cnd,
   output logic [REG_W-1:0] e_dstE_sel,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of,
   output logic [1:0]       M_stat,
   output logic [3:0]       M_icode,
   output logic             M_cnd,
   output logic [WIDTH-1:0] M_valE,
   output logic [WIDTH-1:0] M_valA,
   output logic [REG_W-1:0] M_dstE,
   output logic [REG_W-1:0] M_dstM
);

   localparam logic [REG_W-1:0] RN = '1;

   logic zf_n;
   logic sf_n;
   logic of_n;
   logic cc_we;
   logic cnd_raw;
   logic uses_cnd;

   assign zf_n  = ~|e_valE;
   assign sf_n  = e_valE[WIDTH-1];
   assign of_n  = alu_of(e_ifun, e_of);
   assign cc_we = (e_icode == I_OPQ) && (e_stat == S_AOK) && !cc_block;

   cond_eval u_cond (
      .ifun (e_ifun),
      .zf   (cc_zf),
      .sf   (cc_sf),
      .of   (cc_of),
      .cnd  (cnd_raw)
   );

   assign uses_cnd   = (e_icode == I_JXX) || (e_icode == I_CMOVXX);
   assign e_cnd      = uses_cnd ? cnd_raw : 1'b1;
   assign e_dstE_sel = ((e_icode == I_CMOVXX) && !e_cnd) ? RN : e_dstE;

   // CC ignores m_stall: a stalled M stage must not lose OPQ flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         cc_zf <= 1'b1;
         cc_sf <= 1'b0;
         cc_of <= 1'b0;
      end else if (cc_we) begin
         cc_zf <= zf_n;
         cc_sf <= sf_n;
         cc_of <= of_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || m_bubble) begin
         M_stat  <= S_AOK;
         M_icode <= I_NOP;
         M_cnd   <= 1'b0;
         M_valE  <= '0;
         M_valA  <= '0;
         M_dstE  <= RN;
         M_dstM  <= RN;
      end else if (!m_stall) begin
         M_stat  <= e_stat;
         M_icode <= e_icode;
         M_cnd   <= e_cnd;
         M_valE  <= e_valE;
         M_valA  <= e_valA;
         M_dstE  <= e_dstE_sel;
         M_dstM  <= e_dstM;
      end
   end

endmodule
